// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and helpers for the on-chip memory subordinate.
// Byte-lane selection and address alignment live here so every user agrees on them.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HsizeByte = 3'b000,
    HsizeHalf = 3'b001,
    HsizeWord = 3'b010
  } hsize_e;

  typedef enum logic {
    HrespOkay  = 1'b0,
    HrespError = 1'b1
  } hresp_e;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StErr1,
    StErr2
  } dp_state_e;

  // Little-endian lane mask: bit n enables HWDATA[8n+7:8n].
  function automatic logic [3:0] lane_mask(logic [2:0] size, logic [1:0] addr);
    logic [3:0] mask;
    case (size)
      HsizeByte: mask = 4'b0001 << addr;
      HsizeHalf: mask = addr[1] ? 4'b1100 : 4'b0011;
      HsizeWord: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Low address bits after forcing the address down to the transfer-size boundary.
  function automatic logic [1:0] align_lo(logic [2:0] size, logic [1:0] addr);
    logic [1:0] lo;
    case (size)
      HsizeByte: lo = addr;
      HsizeHalf: lo = {addr[1], 1'b0};
      default:   lo = 2'b00;
    endcase
    return lo;
  endfunction

endpackage

// File: rtl/ahb_lite_byte_ram.sv
// Word-organised RAM with per-byte write enables, combinational read and async clear.
module ahb_lite_byte_ram #(
  parameter int unsigned Words = 64,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Words];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Words; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite subordinate fronting a little-endian byte RAM, with optional wait states
// and the standard two-cycle ERROR response for bad sizes or out-of-range addresses.
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [1:0]  HTRANS,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned AW     = $clog2(MEM_BYTES);
  localparam int unsigned WordAw = (AW > 2) ? AW - 2 : 1;
  localparam int unsigned CntW   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

  dp_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dp_valid_q, dp_valid_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic [2:0]       size_q, size_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             ready_q, ready_d;
  hresp_e           resp_q, resp_d;

  logic             accept;
  logic             addr_err;
  logic [31:0]      aligned32;
  logic             wr_commit;
  logic [3:0]       ram_we;
  logic [WordAw-1:0] word_idx;
  logic [31:0]      ram_rdata;
  logic             unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Address-phase decode
  assign accept    = HSEL & HREADY & HTRANS[1];
  assign aligned32 = {HADDR[31:2], align_lo(HSIZE, HADDR[1:0])};
  assign addr_err  = (|(aligned32 >> AW)) | (HSIZE > HsizeWord);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dp_valid_d = dp_valid_q;
    write_d    = write_q;
    err_d      = err_q;
    size_d     = size_q;
    addr_d     = addr_q;
    ready_d    = ready_q;
    resp_d     = resp_q;
    unique case (state_q)
      StWait: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StErr1: begin
        state_d = StErr2;
        ready_d = 1'b1;
      end
      StIdle, StErr2: begin
        // HREADYOUT is high here, so any data phase in flight ends at this edge.
        state_d    = StIdle;
        ready_d    = 1'b1;
        resp_d     = HrespOkay;
        dp_valid_d = 1'b0;
        if (HREADY) begin
          dp_valid_d = accept;
          write_d    = HWRITE;
          size_d     = HSIZE;
          addr_d     = aligned32[AW-1:0];
          err_d      = accept & addr_err;
          if (accept && addr_err) begin
            state_d = StErr1;
            ready_d = 1'b0;
            resp_d  = HrespError;
          end else if (accept && (WAIT_STATES > 0)) begin
            state_d = StWait;
            ready_d = 1'b0;
            cnt_d   = CntW'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dp_valid_q <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      addr_q     <= '0;
      ready_q    <= 1'b1;
      resp_q     <= HrespOkay;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dp_valid_q <= dp_valid_d;
      write_q    <= write_d;
      err_q      <= err_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      ready_q    <= ready_d;
      resp_q     <= resp_d;
    end
  end

  // Writes land on the edge that closes an OKAY data phase.
  assign wr_commit = dp_valid_q & write_q & ~err_q & (state_q == StIdle);
  assign ram_we    = lane_mask(size_q, addr_q[1:0]) & {4{wr_commit}};
  assign word_idx  = WordAw'(addr_q >> 2);

  ahb_lite_byte_ram #(
    .Words(MEM_BYTES / 4),
    .AddrW(WordAw)
  ) u_ram (
    .clk_i  (HCLK),
    .rst_ni (HRESETn),
    .we_i   (ram_we),
    .addr_i (word_idx),
    .wdata_i(HWDATA),
    .rdata_o(ram_rdata)
  );

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
  assign HRDATA    = (dp_valid_q & ~write_q & ~err_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Bench for ahb_lite_mem_slave: a zero-wait and a two-wait instance driven by a pipelined
// task master, checked every cycle against a byte-array model of the memory and bus rules.
module tb_ahb_lite_mem_slave;

  localparam int unsigned MEM = 256;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } xfer_t;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  always #5 hclk = ~hclk;

  logic [1:0]       hsel, hwrite, hmastlock;
  logic [1:0][31:0] haddr, hwdata;
  logic [1:0][2:0]  hsize, hburst;
  logic [1:0][3:0]  hprot;
  logic [1:0][1:0]  htrans;
  wire  [1:0]       hreadyout, hresp;
  wire  [1:0][31:0] hrdata;

  ahb_lite_mem_slave #(.MEM_BYTES(MEM), .WAIT_STATES(0)) dut0 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(hprot[0]), .HTRANS(htrans[0]),
    .HMASTLOCK(hmastlock[0]), .HREADY(hreadyout[0]), .HWDATA(hwdata[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0])
  );

  ahb_lite_mem_slave #(.MEM_BYTES(MEM), .WAIT_STATES(2)) dut1 (
    .HCLK(hclk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(hprot[1]), .HTRANS(htrans[1]),
    .HMASTLOCK(hmastlock[1]), .HREADY(hreadyout[1]), .HWDATA(hwdata[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mem_m [2][MEM];
  xfer_t xq[$];

  function automatic int ws(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic xfer_t mk(logic sel, logic [1:0] tr, logic wr, logic [31:0] a,
                               logic [2:0] sz, logic [31:0] wd, logic chk, logic [31:0] ex);
    xfer_t t;
    t.sel = sel; t.trans = tr; t.wr = wr; t.addr = a;
    t.size = sz; t.wdata = wd; t.chk = chk; t.exp = ex;
    return t;
  endfunction

  function automatic logic is_active(xfer_t t);
    return t.sel && t.trans[1];
  endfunction

  function automatic logic is_err(xfer_t t);
    logic [31:0] nb;
    if (t.size > 3'd2) return 1'b1;
    nb = 32'd1 << t.size;
    return (t.addr & ~(nb - 32'd1)) >= 32'(MEM);
  endfunction

  function automatic logic [31:0] mword(int d, logic [31:0] a);
    int unsigned b;
    b = a & 32'hFFFF_FFFC;
    return {mem_m[d][b+3], mem_m[d][b+2], mem_m[d][b+1], mem_m[d][b]};
  endfunction

  task automatic apply_write(int d, xfer_t t);
    int unsigned nb, base, a;
    nb   = 1 << t.size;
    base = t.addr & ~(nb - 1);
    for (int unsigned k = 0; k < nb; k++) begin
      a = base + k;
      mem_m[d][a] = t.wdata[8*(a%4) +: 8];
    end
  endtask

  task automatic clear_models();
    for (int d = 0; d < 2; d++)
      for (int unsigned i = 0; i < MEM; i++) mem_m[d][i] = 8'h00;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic drive(int d, xfer_t t);
    hsel[d]   = t.sel;
    htrans[d] = t.trans;
    hwrite[d] = t.wr;
    haddr[d]  = t.addr;
    hsize[d]  = t.size;
    hburst[d] = 3'($urandom);
    hprot[d]  = 4'($urandom);
    hmastlock[d] = 1'($urandom);
  endtask

  // Runs xq on instance d, address phase of each transfer overlapping the previous data phase.
  task automatic run(int d);
    xfer_t prev, cur, idl;
    int cyc;
    bit done;
    logic er, ep;
    logic [31:0] ed;
    idl  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0);
    prev = idl;
    for (int i = 0; i <= xq.size(); i++) begin
      if (i < xq.size()) cur = xq[i];
      else cur = idl;
      drive(d, cur);
      hwdata[d] = prev.wdata;
      cyc  = 0;
      done = 0;
      while (!done) begin
        @(negedge hclk);
        if (!is_active(prev)) begin
          er = 1'b1; ep = 1'b0; ed = '0;
        end else if (is_err(prev)) begin
          er = (cyc == 1); ep = 1'b1; ed = '0;
        end else begin
          er = (cyc == ws(d)); ep = 1'b0;
          ed = prev.wr ? 32'h0 : mword(d, prev.addr);
        end
        check($sformatf("d%0d x%0d c%0d hreadyout", d, i, cyc), 32'(hreadyout[d]), 32'(er));
        check($sformatf("d%0d x%0d c%0d hresp", d, i, cyc), 32'(hresp[d]), 32'(ep));
        check($sformatf("d%0d x%0d c%0d hrdata", d, i, cyc), hrdata[d], ed);
        if (hreadyout[d]) begin
          done = 1;
          if (prev.chk) check($sformatf("d%0d x%0d table_rdata", d, i), hrdata[d], prev.exp);
        end else if (cyc >= 12) begin
          n_tests++;
          n_fail++;
          $display("FAIL d%0d x%0d timeout: hreadyout stayed 0, want 1 within 12 cycles", d, i);
          done = 1;
        end
        @(posedge hclk);
        #1;
        cyc++;
      end
      if (is_active(prev) && !is_err(prev) && prev.wr) apply_write(d, prev);
      prev = cur;
    end
    xq.delete();
  endtask

  initial begin
    xfer_t t, idl;
    idl = mk(0, 2'b00, 0, 0, 0, 0, 0, 0);
    hwdata = '0;
    drive(0, idl);
    drive(1, idl);
    clear_models();

    repeat (2) @(posedge hclk);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset hreadyout", d), 32'(hreadyout[d]), 32'd1);
      check($sformatf("d%0d reset hresp", d), 32'(hresp[d]), 32'd0);
      check($sformatf("d%0d reset hrdata", d), hrdata[d], 32'd0);
    end
    hresetn = 1'b1;
    @(posedge hclk);
    #1;

    // Directed table, zero wait states
    xq.push_back(mk(1, 2'b10, 0, 32'h00,  3'd2, 32'h0,        1, 32'h0000_0000));
    xq.push_back(mk(1, 2'b10, 1, 32'h02,  3'd1, 32'hBEEF0000, 0, 0));
    xq.push_back(mk(1, 2'b10, 0, 32'h00,  3'd2, 32'h0,        1, 32'hBEEF_0000));
    xq.push_back(mk(1, 2'b10, 1, 32'h00,  3'd2, 32'h0,        0, 0));
    xq.push_back(mk(1, 2'b10, 1, 32'h01,  3'd1, 32'h000000AA, 0, 0));
    xq.push_back(mk(1, 2'b10, 0, 32'h00,  3'd2, 32'h0,        1, 32'h0000_00AA));
    xq.push_back(mk(1, 2'b10, 1, 32'h10,  3'd0, 32'h00000011, 0, 0));
    xq.push_back(mk(1, 2'b11, 1, 32'h11,  3'd0, 32'h00002200, 0, 0));
    xq.push_back(mk(1, 2'b11, 1, 32'h12,  3'd0, 32'h00330000, 0, 0));
    xq.push_back(mk(1, 2'b11, 1, 32'h13,  3'd0, 32'h44000000, 0, 0));
    xq.push_back(mk(1, 2'b10, 0, 32'h12,  3'd0, 32'h0,        1, 32'h4433_2211));
    xq.push_back(mk(1, 2'b10, 1, 32'h100, 3'd2, 32'hDEADBEEF, 0, 0));
    xq.push_back(mk(1, 2'b10, 0, 32'h00,  3'd2, 32'h0,        1, 32'h0000_00AA));
    xq.push_back(mk(1, 2'b00, 0, 32'h10,  3'd2, 32'h0,        1, 32'h0));
    xq.push_back(mk(0, 2'b10, 0, 32'h10,  3'd2, 32'h0,        1, 32'h0));
    xq.push_back(mk(1, 2'b10, 0, 32'h10,  3'd3, 32'h0,        1, 32'h0));
    xq.push_back(mk(1, 2'b01, 0, 32'h10,  3'd2, 32'h0,        1, 32'h0));
    xq.push_back(mk(1, 2'b11, 0, 32'h10,  3'd2, 32'h0,        1, 32'h4433_2211));
    run(0);

    // Directed table, two wait states
    xq.push_back(mk(1, 2'b10, 0, 32'h00,  3'd2, 32'h0,        1, 32'h0));
    xq.push_back(mk(1, 2'b00, 0, 32'h00,  3'd2, 32'h0,        1, 32'h0));
    xq.push_back(mk(1, 2'b10, 1, 32'h40,  3'd2, 32'h12345678, 0, 0));
    xq.push_back(mk(1, 2'b00, 0, 32'h00,  3'd2, 32'h0,        0, 0));
    xq.push_back(mk(1, 2'b10, 0, 32'h40,  3'd2, 32'h0,        1, 32'h1234_5678));
    xq.push_back(mk(1, 2'b10, 1, 32'h104, 3'd2, 32'hFFFFFFFF, 0, 0));
    xq.push_back(mk(1, 2'b11, 0, 32'h41,  3'd0, 32'h0,        1, 32'h1234_5678));
    run(1);

    // Reset asserted inside a waited write data phase: no write, outputs reset at once
    t = mk(1, 2'b10, 1, 32'h20, 3'd2, 32'hCAFEF00D, 0, 0);
    drive(1, t);
    @(posedge hclk);
    #1;
    drive(1, idl);
    hwdata[1] = t.wdata;
    @(negedge hclk);
    check("mid_reset wait hreadyout", 32'(hreadyout[1]), 32'd0);
    #2;
    hresetn = 1'b0;
    #1;
    check("mid_reset hreadyout", 32'(hreadyout[1]), 32'd1);
    check("mid_reset hresp", 32'(hresp[1]), 32'd0);
    check("mid_reset hrdata", hrdata[1], 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk);
    #1;
    clear_models();
    xq.push_back(mk(1, 2'b10, 0, 32'h20, 3'd2, 32'h0, 1, 32'h0));
    run(1);

    // Randomised traffic against the byte model
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        t.sel   = ($urandom_range(0, 7) != 0);
        t.trans = 2'($urandom);
        t.wr    = 1'($urandom);
        t.addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, MEM + 15));
        t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                              : 3'($urandom_range(0, 2));
        t.wdata = 32'($urandom);
        t.chk   = 1'b0;
        t.exp   = '0;
        xq.push_back(t);
      end
      run(d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_lite_mem_slave.md
Name: ahb_lite_mem_slave

Overview:
- AHB-Lite subordinate backed by a byte-addressed, little-endian on-chip RAM.
- Decodes address/control in the address phase, then completes the transfer in the following data phase.
- Supports byte, halfword and word accesses, a configurable number of wait states, and a two-cycle ERROR response.
- Sits behind the system decoder/multiplexer; driven in test by the team's task-based AHB-Lite master.

Parameters:
- MEM_BYTES, 256: RAM size in bytes; must be a power of two, at least 4.
- WAIT_STATES, 0: HREADYOUT-low cycles inserted at the start of every OKAY NONSEQ/SEQ data phase.

Ports:
- HCLK  in  1  clock, rising edge.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  1  slave select from decoder.
- HADDR  in  32  byte address.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HBURST  in  3  accepted, ignored.
- HPROT  in  4  accepted, ignored.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HMASTLOCK  in  1  accepted, ignored.
- HREADY  in  1  bus-level ready (muxed HREADYOUT).
- HWDATA  in  32  write data, valid in data phase.
- HREADYOUT  out  1  transfer-done / slave ready.
- HRESP  out  1  0 OKAY, 1 ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset (async assert): HREADYOUT=1, HRESP=0, HRDATA=0, every RAM byte = 0x00, any pending data phase discarded.
- Reset release is synchronous to HCLK.
- Address phase is accepted when HSEL & HREADY & HTRANS[1] at a rising edge. The registered controls are: aligned address, HWRITE, HSIZE, error flag.
- Alignment: the address is forced down to the HSIZE boundary (halfword clears bit0, word clears bits1:0). No error is raised for misalignment.
- ERROR is flagged when either condition holds:
  - HSIZE > 010.
  - Aligned address ≥ MEM_BYTES (the upper address bits are compared).
- IDLE, BUSY, or HSEL=0 accepted phases: next data phase is zero-wait OKAY (HREADYOUT=1, HRESP=0), with no RAM access.
- OKAY data phase:
  - HREADYOUT=0 for WAIT_STATES cycles, then 1 for one cycle.
  - HRESP=0 throughout.
  - Total length is WAIT_STATES+1 cycles.
- ERROR data phase: exactly two cycles, ignoring WAIT_STATES.
  - Cycle 1: HRESP=1, HREADYOUT=0.
  - Cycle 2: HRESP=1, HREADYOUT=1.
  - Nothing is written.
- Writes: the lanes selected by HSIZE and the aligned address are written at the rising edge ending the data phase (HREADYOUT=1). Lanes are little-endian: byte n of a word is HWDATA[8n+7:8n]. Other bytes are unchanged.
- Reads: HRDATA is combinational from the RAM word containing the registered address, and is driven with the whole 32-bit word (all lanes) during the read data phase, including wait cycles. The master selects the lane. In all other cycles HRDATA=0.
- Back-to-back pipelining:
  - A new address phase overlapping the final data-phase cycle is accepted.
  - Write followed by a read of the same word: the read returns the new data, because the write commits at the edge before the read's data phase.
- New address phases are not accepted while HREADY=0. Control registers hold.
- Reset mid-transfer: the transfer is aborted with no partial write, and outputs take their reset values immediately.

Decomposition:
- Package ahb_lite_pkg holds:
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE codes BYTE/HALFWORD/WORD.
  - HRESP codes OKAY/ERROR.
  - A function returning the 4-bit byte-lane mask from HSIZE and addr[1:0].
- One sub-module is natural: ahb_lite_byte_ram, holding MEM_BYTES/4 words with a 4-bit byte write-enable, a combinational read port and async clear.
- The top level holds the address-phase registers and the data-phase FSM with states IDLE, WAIT, ERR1, ERR2.
  - IDLE→WAIT: WAIT_STATES>0.
  - IDLE→ERR1: flagged error.
  - WAIT→IDLE: wait count exhausted, completing the transfer.
  - ERR1→ERR2, then ERR2→IDLE.

Test Plan:
- Reset check: hold HRESETn=0 → HREADYOUT=1, HRESP=0, HRDATA=0. After release, a word read at 0x00 returns 0x00000000.
- Halfword write HADDR=0x02 with HWDATA=0xBEEF0000, then word read at 0x00 → HRDATA=0xBEEF0000. The read is issued back-to-back, and HREADYOUT stays 1 throughout with WAIT_STATES=0.
- Misaligned halfword write HADDR=0x01 with HWDATA=0x000000AA, then word read at 0x00 → 0x000000AA (alignment to 0x00).
- Byte writes 0x11,0x22,0x33,0x44 to 0x10..0x13 on the proper lanes, followed by byte read 0x12 → HRDATA=0x44332211.
- HADDR=MEM_BYTES (0x100) word write → two-cycle ERROR (HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1). RAM is unchanged.
- WAIT_STATES=2: NONSEQ read → HREADYOUT low for 2 cycles then high. An IDLE transfer interleaved between NONSEQs gets a zero-wait OKAY response.
